// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control, note handshake and display signals of the melody sequencer
interface melody_sequencer_if;
  logic       start;
  logic       stop;
  logic       tempo_fast;
  logic       note_ready;
  logic [3:0] note;
  logic       note_valid;
  logic       mute;
  logic       busy;
  logic [3:0] step;
  logic       done;

  modport master (
    input  start, stop, tempo_fast, note_ready,
    output note, note_valid, mute, busy, step, done
  );

  modport slave (
    output start, stop, tempo_fast, note_ready,
    input  note, note_valid, mute, busy, step, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps a 16-entry note ROM, hands notes to the tone generator, times notes and gaps
// Optional LOOP_PLAY_EN: restart from step 0 at end of melody instead of returning to idle.
module melody_sequencer #(
  parameter int clk_mhz              = 50,
  parameter int beat_ms              = 125,
  parameter int beat_cycles_override = 0,
  parameter int gap_beats            = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  melody_sequencer_if.master   bus
);

  localparam int BEAT_CYCLES = (beat_cycles_override != 0) ? beat_cycles_override
                                                            : clk_mhz * 1000 * beat_ms;
  localparam int FAST_CYCLES = (BEAT_CYCLES / 2 > 0) ? BEAT_CYCLES / 2 : 1;
  localparam int BEAT_W      = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] SLOW_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] FAST_LAST = BEAT_W'(FAST_CYCLES - 1);
  localparam logic [7:0]        GAP_LEN   = 8'(gap_beats);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  function automatic logic [3:0] rom_note(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'd1;
      4'd1:    return 4'd5;
      4'd2:    return 4'd0;
      4'd3:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] rom_dur(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'd2;
      4'd1:    return 4'd1;
      4'd2:    return 4'd1;
      4'd3:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [7:0]        dur_q, dur_d;
  logic              tempo_q, tempo_d;
  logic [3:0]        note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              mute_q, mute_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BEAT_W-1:0] beat_last;
  logic              beat_tick;
  logic              at_end;
  logic              handshake;
  logic              next_end;

  assign beat_last = tempo_q ? FAST_LAST : SLOW_LAST;
  assign beat_tick = (beat_q == beat_last);
  // Stepping past entry 15 is treated exactly like a zero-duration entry.
  assign at_end    = wrap_q || (rom_dur(step_q) == 4'd0);
  assign handshake = note_valid_q && bus.note_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= 4'd0;
      wrap_q       <= 1'b0;
      beat_q       <= '0;
      dur_q        <= 8'd0;
      tempo_q      <= 1'b0;
      note_q       <= 4'd0;
      note_valid_q <= 1'b0;
      mute_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      wrap_q       <= wrap_d;
      beat_q       <= beat_d;
      dur_q        <= dur_d;
      tempo_q      <= tempo_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      mute_q       <= mute_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wrap_d  = wrap_q;
    beat_d  = beat_q;
    dur_d   = dur_q;
    tempo_d = tempo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          step_d  = 4'd0;
          wrap_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (at_end) begin
`ifdef LOOP_PLAY_EN
          state_d = S_LOAD;
          step_d  = 4'd0;
          wrap_d  = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end else if (handshake) begin
          state_d = S_PLAY;
          beat_d  = '0;
          dur_d   = {4'd0, rom_dur(step_q)};
          tempo_d = bus.tempo_fast;
        end
      end
      S_PLAY, S_GAP: begin
        beat_d = beat_tick ? '0 : beat_q + BEAT_W'(1);
        if (beat_tick) begin
          if (dur_q != 8'd1) begin
            dur_d = dur_q - 8'd1;
          end else if (state_q == S_PLAY && GAP_LEN != 8'd0) begin
            state_d = S_GAP;
            dur_d   = GAP_LEN;
          end else begin
            state_d = S_LOAD;
            if (step_q == 4'd15) wrap_d = 1'b1;
            else                 step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.stop) begin
      state_d = S_IDLE;
      beat_d  = '0;
      dur_d   = 8'd0;
    end
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    next_end     = wrap_d || (rom_dur(step_d) == 4'd0);
    busy_d       = (state_d != S_IDLE);
    note_valid_d = (state_d == S_LOAD) && !next_end;
    note_d       = note_q;
    if (state_d == S_IDLE)
      note_d = 4'd0;
    else if (state_d == S_LOAD)
      note_d = next_end ? 4'd0 : rom_note(step_d);
    mute_d = !((state_d == S_PLAY) && (note_d != 4'd0));
    done_d = (state_q == S_LOAD) && at_end && !bus.stop;
  end

  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.mute       = mute_q;
  assign bus.busy       = busy_q;
  assign bus.step       = step_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized bench for melody_sequencer against an expanded expected-cycle trace
module tb_melody_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  melody_sequencer_if bus();

  melody_sequencer #(
    .clk_mhz(50), .beat_ms(125), .beat_cycles_override(BEAT), .gap_beats(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       start;
    bit       stop;
    bit       ready;
    bit       tempo;
    bit       nv;
    bit [3:0] note;
    bit       mute;
    bit       busy;
    bit       done;
    bit       chk_step;
    bit [3:0] step;
  } cyc_t;

  cyc_t tr[$];
  int   rom_note[16];
  int   rom_dur[16];

  function automatic cyc_t idle_rec();
    cyc_t c;
    c.start = 1'b0;  c.stop = 1'b0;
    c.ready = 1'($urandom_range(0, 1));
    c.tempo = 1'($urandom_range(0, 1));
    c.nv = 1'b0;  c.note = 4'd0;  c.mute = 1'b1;  c.busy = 1'b0;
    c.done = 1'b0;  c.chk_step = 1'b0;  c.step = 4'd0;
    return c;
  endfunction

  function automatic cyc_t busy_rec(input int k);
    cyc_t c;
    c = idle_rec();
    c.busy = 1'b1;
    c.chk_step = 1'b1;
    c.step = 4'(k);
    return c;
  endfunction

  // Expands one melody pass into the expected per-cycle outputs and the inputs to drive.
  task automatic build(input int stall_max, input bit rand_tempo, input bit rand_start);
    cyc_t c;
    int   lim;
    int   stall;
    bit   tk;
    tr.delete();
    c = idle_rec();
    c.start = 1'b1;
    tr.push_back(c);
    for (int k = 0; k <= 16; k++) begin
      if (k == 16 || rom_dur[k] == 0) begin
        c = busy_rec(k == 16 ? 15 : k);
        tr.push_back(c);
        c = idle_rec();
        c.done = 1'b1;
`ifdef LOOP_PLAY_EN
        c.busy = 1'b1;  c.nv = 1'b1;  c.note = 4'(rom_note[0]);
        c.chk_step = 1'b1;  c.step = 4'd0;  c.stop = 1'b1;
`endif
        tr.push_back(c);
        break;
      end
      tk    = rand_tempo ? 1'($urandom_range(0, 1)) : 1'b0;
      stall = (stall_max == 0) ? 0 : ((k == 0) ? stall_max : $urandom_range(0, stall_max));
      for (int i = 0; i <= stall; i++) begin
        c = busy_rec(k);
        c.nv = 1'b1;
        c.note = 4'(rom_note[k]);
        c.ready = (i == stall);
        if (i == stall) c.tempo = tk;
        tr.push_back(c);
      end
      lim = tk ? BEAT / 2 : BEAT;
      for (int i = 0; i < rom_dur[k] * lim; i++) begin
        c = busy_rec(k);
        c.mute = (rom_note[k] == 0);
        tr.push_back(c);
      end
      for (int i = 0; i < GAP * lim; i++) begin
        c = busy_rec(k);
        tr.push_back(c);
      end
    end
    repeat (3) tr.push_back(idle_rec());
    if (rand_start) begin
      for (int i = 1; i < tr.size(); i++)
        if (tr[i].busy) tr[i].start = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic apply_stop(input int at);
    cyc_t c;
    tr[at].stop = 1'b1;
    while (tr.size() > at + 1) void'(tr.pop_back());
    tr.push_back(idle_rec());
    c = idle_rec();
    c.start = 1'b1;
    c.stop  = 1'b1;
    tr.push_back(c);
    repeat (3) tr.push_back(idle_rec());
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < tr.size(); i++) begin
      @(posedge clk);
      #1;
      bus.start      = tr[i].start;
      bus.stop       = tr[i].stop;
      bus.note_ready = tr[i].ready;
      bus.tempo_fast = tr[i].tempo;
      @(negedge clk);
      total++;
      if ({bus.note_valid, bus.mute, bus.busy, bus.done} !== {tr[i].nv, tr[i].mute, tr[i].busy, tr[i].done}) begin
        bad++;
        $display("FAIL %s ctrl cyc=%0d got nv,mute,busy,done=%b want=%b", tag, i,
                 {bus.note_valid, bus.mute, bus.busy, bus.done},
                 {tr[i].nv, tr[i].mute, tr[i].busy, tr[i].done});
      end
      if (tr[i].chk_step) begin
        total++;
        if (bus.step !== tr[i].step) begin
          bad++;
          $display("FAIL %s step cyc=%0d got=%0d want=%0d", tag, i, bus.step, tr[i].step);
        end
      end
      if (tr[i].nv) begin
        total++;
        if (bus.note !== tr[i].note) begin
          bad++;
          $display("FAIL %s note cyc=%0d got=%0d want=%0d", tag, i, bus.note, tr[i].note);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({bus.note_valid, bus.mute, bus.busy, bus.done} !== 4'b0100) begin
      bad++;
      $display("FAIL %s ctrl got nv,mute,busy,done=%b want=0100", tag,
               {bus.note_valid, bus.mute, bus.busy, bus.done});
    end
    total++;
    if (bus.step !== 4'd0) begin
      bad++;
      $display("FAIL %s step got=%0d want=0", tag, bus.step);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    build(0, 1'b0, 1'b0);
    run("basic");
  endtask

  task automatic test_ready_stall();
    build(5, 1'b0, 1'b0);
    run("stall");
  endtask

  task automatic test_tempo();
    build(0, 1'b1, 1'b0);
    run("tempo");
  endtask

  task automatic test_stop();
    build(0, 1'b0, 1'b0);
    apply_stop(33 + $urandom_range(0, 15));
    run("stop");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      build(3, 1'b1, 1'b1);
      run("b2b");
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat ($urandom_range(3, 30)) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("mid_reset");
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_note[i] = 0;
      rom_dur[i]  = 0;
    end
    rom_note[0] = 1; rom_dur[0] = 2;
    rom_note[1] = 5; rom_dur[1] = 1;
    rom_note[2] = 0; rom_dur[2] = 1;
    rom_note[3] = 8; rom_dur[3] = 4;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.tempo_fast = 1'b0;
    bus.note_ready = 1'b1;
    test_reset();
    test_basic();
    test_ready_stall();
    test_tempo();
    test_stop();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
